// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row synchronizer and debounce, and the
// button/bstate/readInput/keyPulse key-event interface for the lock.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] button,
  output logic       bstate,
  output logic       readInput,
  output logic       keyPulse
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  // A good sample taken with the counter here brings it to DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXC - 1);

  typedef enum logic [2:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE, REL_HOLD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    rs1_q, rs_q;
  logic [3:0]    button_q, button_d;
  logic          bstate_q, bstate_d;
  logic          rd_q, rd_d;
  logic          kp_q, kp_d;

  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    low_idx;
  logic          press_ok;
  logic          row_high;
  logic [CW-1:0] deb_inc;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_code = 4'd1;
      4'b00_01: key_code = 4'd2;
      4'b00_10: key_code = 4'd3;
      4'b00_11: key_code = 4'd10;
      4'b01_00: key_code = 4'd4;
      4'b01_01: key_code = 4'd5;
      4'b01_10: key_code = 4'd6;
      4'b01_11: key_code = 4'd11;
      4'b10_00: key_code = 4'd7;
      4'b10_01: key_code = 4'd8;
      4'b10_10: key_code = 4'd9;
      4'b10_11: key_code = 4'd12;
      4'b11_00: key_code = 4'd14;
      4'b11_01: key_code = 4'd0;
      4'b11_10: key_code = 4'd15;
      default:  key_code = 4'd13;
    endcase
  endfunction

  always_comb begin
    low      = ~rs_q;
    one_low  = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    low_idx  = 2'd0;
    for (int i = 0; i < 4; i++)
      if (low[i]) low_idx = 2'(i);
    press_ok = (rs_q == ~(4'b0001 << row_q));
    row_high = rs_q[row_q];
    deb_inc  = (deb_q == CNT_MAX) ? deb_q : deb_q + 1'b1;
  end

  // State register, synchronizer and registered outputs.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q  <= SCAN;
      div_q    <= '0;
      deb_q    <= '0;
      col_q    <= 2'd0;
      row_q    <= 2'd0;
      rs1_q    <= 4'hF;
      rs_q     <= 4'hF;
      button_q <= 4'd0;
      bstate_q <= 1'b0;
      rd_q     <= 1'b0;
      kp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      deb_q    <= deb_d;
      col_q    <= col_d;
      row_q    <= row_d;
      rs1_q    <= row_n;
      rs_q     <= rs1_q;
      button_q <= button_d;
      bstate_q <= bstate_d;
      rd_q     <= rd_d;
      kp_q     <= kp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    deb_d   = deb_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (one_low) begin
            row_d   = low_idx;
            deb_d   = '0;
            state_d = DEB_PRESS;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else if (div_q != CNT_MAX) begin
          div_d = div_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (press_ok) begin
          deb_d = deb_inc;
          if (deb_q == DEB_LAST) state_d = HELD;
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end
      end
      HELD: begin
        if (row_high) begin
          deb_d   = '0;
          state_d = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (!row_high) begin
          state_d = HELD;
        end else begin
          deb_d = deb_inc;
          if (deb_q == DEB_LAST) state_d = REL_HOLD;
        end
      end
      REL_HOLD: begin
        state_d = SCAN;
        col_d   = col_q + 2'd1;
        div_d   = '0;
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    button_d = button_q;
    bstate_d = bstate_q;
    rd_d     = rd_q;
    kp_d     = 1'b0;
    case (state_q)
      DEB_PRESS: begin
        if (press_ok && deb_q == DEB_LAST) begin
          button_d = key_code(row_q, col_q);
          bstate_d = 1'b1;
          rd_d     = 1'b1;
          kp_d     = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (row_high && deb_q == DEB_LAST) bstate_d = 1'b0;
      end
      REL_HOLD: rd_d = 1'b0;
      default: ;
    endcase
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign button    = button_q;
  assign bstate    = bstate_q;
  assign readInput = rd_q;
  assign keyPulse  = kp_q;

endmodule
